muldiv_div_seq: RTL and testbench

Parametrised iterative integer divider for the core's M-extension datapath: the multi-cycle successor to the combinational divide-operand conditioning stage. Accepts DIV/DIVU/REM/REMU (and RV64 word forms) over a valid/ready request, conditions operands, resolves divide-by-zero and signed overflow early, otherwise runs a radix-2 restoring loop and returns a sign-corrected result over a valid/ready response. Sits between EX-stage operand muxing and the writeback result mux.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/md_operand_cond.sv | 50 +++++
 rtl/muldiv_div_seq.sv | 166 ++++++++++++++++
 tb/tb_muldiv_div_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_pkg : shared op-field positions and FSM encodings          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package muldiv_pkg;

  localparam int OP_WORD = 2;
  localparam int OP_REM  = 1;
  localparam int OP_UNS  = 0;

  typedef logic [1:0] md_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Early-out constants for 32-bit (word) operands.
  localparam logic [31:0] WORD_MIN  = 32'h8000_0000;
  localparam logic [31:0] WORD_ONES = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/md_operand_cond.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_operand_cond : word truncation, abs/zero-extend, early flags   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module md_operand_cond
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] x_i,
  input  logic [XLEN-1:0] y_i,
  output logic            word_o,
  output logic [XLEN-1:0] x_trunc_o,
  output logic [XLEN-1:0] x_mag_o,
  output logic [XLEN-1:0] y_mag_o,
  output logic            x_neg_o,
  output logic            y_neg_o,
  output logic            div_zero_o,
  output logic            ovf_o
);

  localparam logic [XLEN-1:0] LOW32 = XLEN'(64'h0000_0000_FFFF_FFFF);
  localparam logic [XLEN-1:0] MIN32 = XLEN'({32'h0, WORD_MIN});
  localparam logic [XLEN-1:0] MINX  = {1'b1, {(XLEN-1){1'b0}}};

  logic            w_signed;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_x;
  logic [XLEN-1:0] w_y;

  always_comb begin
    word_o     = (XLEN == 64) && op_i[OP_WORD];
    w_signed   = !op_i[OP_UNS];
    w_mask     = word_o ? LOW32 : '1;
    w_x        = x_i & w_mask;
    w_y        = y_i & w_mask;
    x_neg_o    = w_signed && (word_o ? x_i[31] : x_i[XLEN-1]);
    y_neg_o    = w_signed && (word_o ? y_i[31] : y_i[XLEN-1]);
    // Masking after negation keeps word magnitudes confined to 32 bits.
    x_mag_o    = (x_neg_o ? -w_x : w_x) & w_mask;
    y_mag_o    = (y_neg_o ? -w_y : w_y) & w_mask;
    x_trunc_o  = w_x;
    div_zero_o = (w_y == '0);
    ovf_o      = w_signed && (w_x == (word_o ? MIN32 : MINX)) && (w_y == w_mask);
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_div_seq : radix-2 restoring divider, valid/ready handshake |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module muldiv_div_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            kill_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] x_i,
  input  logic [XLEN-1:0] y_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  localparam int              CW    = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] LOW32 = XLEN'(64'h0000_0000_FFFF_FFFF);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            word_q, word_d;
  logic            rsel_q, rsel_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  logic            w_word, w_x_neg, w_y_neg, w_div_zero, w_ovf;
  logic [XLEN-1:0] w_x, w_x_mag, w_y_mag;

  md_operand_cond #(.XLEN(XLEN)) u_cond (
    .op_i       (op_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .word_o     (w_word),
    .x_trunc_o  (w_x),
    .x_mag_o    (w_x_mag),
    .y_mag_o    (w_y_mag),
    .x_neg_o    (w_x_neg),
    .y_neg_o    (w_y_neg),
    .div_zero_o (w_div_zero),
    .ovf_o      (w_ovf)
  );

  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_quo, w_rmd, w_early, w_pre, w_res;
  logic            w_wsel;

  // The stored remainder is always below the divisor, so its extra bit is
  // only needed on the shifted trial value.
  always_comb begin
    w_shift = {rem_q, dvd_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, dvs_q};
    w_qbit  = !w_diff[XLEN];
    w_quo   = negq_q ? -dvd_q : dvd_q;
    w_rmd   = negr_q ? -rem_q : rem_q;
    w_early = w_div_zero ? (op_i[OP_REM] ? w_x : '1) : (op_i[OP_REM] ? '0 : w_x);
    w_pre   = (state_q == ST_FIX) ? (rsel_q ? w_rmd : w_quo) : w_early;
    w_wsel  = (state_q == ST_FIX) ? word_q : w_word;
    w_res   = w_pre;
    if (w_wsel) begin
      w_res = w_pre[31] ? (w_pre | ~LOW32) : (w_pre & LOW32);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    word_d  = word_q;
    rsel_d  = rsel_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            word_d = w_word;
            rsel_d = op_i[OP_REM];
            negq_d = w_x_neg ^ w_y_neg;
            negr_d = w_x_neg;
            dvs_d  = w_y_mag;
            // Word dividends are left-aligned so the loop always consumes the MSB.
            dvd_d  = w_word ? (w_x_mag << 32) : w_x_mag;
            rem_d  = '0;
            cnt_d  = w_word ? CW'(32) : CW'(XLEN);
            if (w_div_zero || w_ovf) begin
              res_d   = w_res;
              state_d = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_d = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
          dvd_d = {dvd_q[XLEN-2:0], w_qbit};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          res_d   = w_res;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (res_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      word_q  <= 1'b0;
      rsel_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      word_q  <= word_d;
      rsel_q  <= rsel_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_o       = res_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_muldiv_div_seq : scoreboard bench for XLEN=32 and XLEN=64 DUTs |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_muldiv_div_seq;

  logic        clk = 1'b0;
  logic        reset_i, kill_i, req_valid, rdy;
  logic [2:0]  op;
  logic [63:0] x, y;
  logic [1:0]  req_ready, res_valid, busy;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [63:0] res [2];
  int          rdy_mode;
  longint      cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [63:0] val;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t sb [2][$];
  bit   seen [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign res[0] = {32'h0, res32};
  assign res[1] = res64;

  muldiv_div_seq #(.XLEN(32)) u_dut32 (
    .clk_i(clk), .reset_i(reset_i), .kill_i(kill_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .op_i(op),
    .x_i(x[31:0]), .y_i(y[31:0]), .res_valid_o(res_valid[0]),
    .res_ready_i(rdy), .res_o(res32), .busy_o(busy[0])
  );

  muldiv_div_seq #(.XLEN(64)) u_dut64 (
    .clk_i(clk), .reset_i(reset_i), .kill_i(kill_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .op_i(op),
    .x_i(x), .y_i(y), .res_valid_o(res_valid[1]),
    .res_ready_i(rdy), .res_o(res64), .busy_o(busy[1])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, got no response, expected completion", nm);
  endtask

  // Reference: RISC-V M-extension divide semantics computed with plain arithmetic.
  function automatic logic [63:0] model(input int xl, input logic [2:0] o,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q64, r64, rv;
    bit          early;
    early = 1'b0;
    if (xl == 32 || o[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'h0) begin
        q32 = '1; r32 = a32; early = 1'b1;
      end else if (!o[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0; early = 1'b1;
      end else if (o[0]) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end
      rv = o[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      if (xl == 32) rv[63:32] = 32'h0;
      lat = early ? 1 : 34;
    end else begin
      if (b == 64'h0) begin
        q64 = '1; r64 = a; early = 1'b1;
      end else if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q64 = a; r64 = '0; early = 1'b1;
      end else if (o[0]) begin
        q64 = a / b; r64 = a % b;
      end else begin
        q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
      end
      rv  = o[1] ? r64 : q64;
      lat = early ? 1 : 66;
    end
    return rv;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input bit push);
    int   n = 0;
    exp_t e;
    while (req_ready != 2'b11 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) timeout("issue_wait_ready");
    op = o; x = a; y = b; req_valid = 1'b1;
    @(negedge clk);
    if (push) begin
      for (int i = 0; i < 2; i++) begin
        e.val = model(i == 0 ? 32 : 64, o, a, b, e.lat);
        e.acc = cyc;
        sb[i].push_back(e);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || req_ready != 2'b11) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) timeout("wait_idle");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'h3);
    check({tag, "_res_valid"}, 64'(res_valid), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_res32"}, res[0], 64'h0);
    check({tag, "_res64"}, res[1], 64'h0);
  endtask

  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rdy = 1'($urandom_range(0, 1));
        1:       rdy = 1'b0;
        default: rdy = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each result handshake and checks
  // value stability and latency while the result is presented.
  always @(negedge clk) begin
    if (reset_i === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy_vs_ready%0d", i), 64'(busy[i]), 64'(!req_ready[i]));
        if (res_valid[i]) begin
          check($sformatf("ready_low_in_done%0d", i), 64'(req_ready[i]), 64'h0);
          if (sb[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid%0d: got res_valid=1 res=0x%h, expected no result", i, res[i]);
          end else begin
            if (!seen[i]) begin
              check($sformatf("latency%0d", i), 64'(cyc - sb[i][0].acc), 64'(sb[i][0].lat));
              seen[i] = 1'b1;
            end
            check($sformatf("result%0d", i), res[i], sb[i][0].val);
            if (rdy) begin
              void'(sb[i].pop_front());
              seen[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] rx, ry;
    int          n;
    reset_i = 1'b0; kill_i = 1'b0; req_valid = 1'b0; rdy_mode = 2;
    op = 3'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    reset_i = 1'b1;
    @(posedge clk); #1;

    issue(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(3'b001, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1);
    issue(3'b011, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1);
    issue(3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(3'b010, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(3'b100, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
    issue(3'b111, 64'h0000_0000_0000_0007, 64'h0000_0001_0000_0000, 1'b1);
    wait_idle();

    // Back-pressure: result must hold while the consumer stalls.
    rdy_mode = 1;
    issue(3'b001, 64'd100, 64'd7, 1'b1);
    n = 0;
    while (!res_valid[1] && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) timeout("stall_wait_valid");
    repeat (5) @(posedge clk);
    #1 rdy_mode = 2;
    wait_idle();

    // Flush in the middle of CALC, then a flush coinciding with a request.
    issue(3'b000, 64'h0123_4567_89AB_CDEF, 64'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 kill_i = 1'b1;
    @(posedge clk); #1 kill_i = 1'b0;
    check("kill_ready", 64'(req_ready), 64'h3);
    check("kill_valid", 64'(res_valid), 64'h0);
    kill_i = 1'b1; req_valid = 1'b1; op = 3'b001; x = 64'd50; y = 64'd5;
    @(posedge clk); #1 kill_i = 1'b0; req_valid = 1'b0;
    check("kill_req_not_taken", 64'(busy), 64'h0);

    // Asynchronous reset mid-operation, checked before any further clock edge.
    issue(3'b001, 64'hFFFF_0000_1234_5678, 64'd9, 1'b0);
    repeat (5) @(posedge clk);
    #2 reset_i = 1'b0;
    #1 check_reset_vals("async_rst");
    @(posedge clk); #1 reset_i = 1'b1;
    issue(3'b000, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1);
    wait_idle();

    rdy_mode = 0;
    for (int k = 0; k < 40; k++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ry = 64'h0;
        1: ry = '1;
        2: ry = 64'($urandom_range(1, 20));
        3: ry = {$urandom, 32'h0};
        4: rx = 64'h8000_0000_0000_0000;
        5: rx = {$urandom, 32'h8000_0000};
        default: ;
      endcase
      issue(3'($urandom_range(0, 7)), rx, ry, 1'b1);
    end
    wait_idle();
    rdy_mode = 2;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
